// File: rtl/dram_pattern_tester.sv
// dram_pattern_tester
//   Fill-and-verify engine for the SDRAM controller master port. START
//   writes a generated pattern over [BASE_ADDR, BASE_ADDR+LENGTH), then
//   reads the window back with up to MAX_RD_PEND reads in flight and
//   compares every returned word against the regenerated pattern.
//
//   Optional build macro: DRAM_TESTER_LFSR_EN
//     defined   : MODE=2 uses a Galois LFSR pattern seeded from SEED.
//     undefined : no LFSR logic; MODE=2 behaves exactly like MODE=0.
//
//   Ports
//     CLK, RESET_N         clock, async active-low reset
//     START, ABORT         start request (IDLE only), level abort
//     MODE                 0 incr, 1 affine, 2 LFSR, 3 address complement
//     BASE_ADDR/LENGTH/SEED  window and seed, captured at START
//     BUSY, DONE, PASS     run status; DONE is a one-cycle pulse
//     ERR_COUNT            saturating mismatch count
//     FIRST_ERR_ADDR/DATA  address and read data of the first mismatch
//     MEM_*                master port, active-low strobes, WAITREQUEST
//                          stalls, MEM_RDVALID returns in issue order
//
//   state  | meaning
//   IDLE   | waiting for START
//   WRITE  | presenting pattern writes, one word per accept
//   READ   | issuing reads, comparing returns
//   DRAIN  | all reads issued (or aborted), waiting for returns
//   FINISH | one-cycle DONE pulse, PASS update
module dram_pattern_tester #(
    parameter int unsigned ADDR_W      = 25,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned MUL         = 3,
    parameter int unsigned MAX_RD_PEND = 4,
    parameter int unsigned ERR_W       = 16
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic              ABORT,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [ADDR_W-1:0] LENGTH,
    input  logic [DATA_W-1:0] SEED,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERR_COUNT,
    output logic [ADDR_W-1:0] FIRST_ERR_ADDR,
    output logic [DATA_W-1:0] FIRST_ERR_DATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic [1:0]        MEM_BE_N,
    output logic              MEM_WR_N,
    output logic              MEM_RD_N,
    input  logic              MEM_WAITREQUEST,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_RDVALID
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_FINISH
    } state_t;

    localparam logic [3:0] PEND_MAX = 4'(MAX_RD_PEND);

`ifdef DRAM_TESTER_LFSR_EN
    // Right-shifting Galois masks; bit (tap-1) set for each tap.
    // 16 bits: taps 16,14,13,11. Widths without an entry reuse the 16-bit taps.
    localparam logic [DATA_W-1:0] LFSR_MASK =
        (DATA_W == 8)  ? DATA_W'(8'hB8) :
        (DATA_W == 32) ? DATA_W'(32'h8020_0003) :
                         DATA_W'(16'hB400);
`endif

    state_t            state;
    logic [1:0]        mode_q;
    logic              aborted;
    logic [ADDR_W-1:0] wr_left;
    logic [ADDR_W-1:0] rd_left;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic [DATA_W-1:0] cmp_pat;
    logic [3:0]        pending;
    logic [3:0]        pend_next;

    logic wr_acc;
    logic rd_acc;
    logic rd_ret;
    logic mismatch;

    // Patterns are generated incrementally: the word for index i+1 is a
    // cheap function of the word for index i, so no multiplier is needed.
    function automatic logic [DATA_W-1:0] init_pat(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [ADDR_W-1:0] b);
        case (m)
`ifdef DRAM_TESTER_LFSR_EN
            2'd2:    return (s == '0) ? DATA_W'(1) : s;
`endif
            2'd3:    return ~DATA_W'(b);
            default: return s;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] step_pat(input logic [1:0] m,
                                                   input logic [DATA_W-1:0] p);
        case (m)
            2'd1:    return p + DATA_W'(MUL);
`ifdef DRAM_TESTER_LFSR_EN
            2'd2:    return (p >> 1) ^ (p[0] ? LFSR_MASK : '0);
`endif
            // ~(b+i+1) == ~(b+i) - 1
            2'd3:    return p - DATA_W'(1);
            default: return p + DATA_W'(1);
        endcase
    endfunction

    assign MEM_BE_N = 2'b00;

    assign wr_acc   = (state == S_WRITE) && !MEM_WR_N && !MEM_WAITREQUEST;
    assign rd_acc   = (state == S_READ)  && !MEM_RD_N && !MEM_WAITREQUEST;
    // Returns with nothing outstanding are stale and dropped.
    assign rd_ret   = ((state == S_READ) || (state == S_DRAIN)) && MEM_RDVALID
                      && (pending != 4'd0);
    assign mismatch = rd_ret && (MEM_RDATA != cmp_pat);

    always_comb begin
        pend_next = pending;
        if (rd_acc) pend_next = pend_next + 4'd1;
        if (rd_ret) pend_next = pend_next - 4'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= S_IDLE;
            mode_q         <= 2'd0;
            aborted        <= 1'b0;
            wr_left        <= '0;
            rd_left        <= '0;
            issue_addr     <= '0;
            cmp_addr       <= '0;
            cmp_pat        <= '0;
            pending        <= 4'd0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            ERR_COUNT      <= '0;
            FIRST_ERR_ADDR <= '0;
            FIRST_ERR_DATA <= '0;
            MEM_ADDR       <= '0;
            MEM_WDATA      <= '0;
            MEM_WR_N       <= 1'b1;
            MEM_RD_N       <= 1'b1;
        end else begin
            DONE    <= 1'b0;
            pending <= pend_next;

            if (rd_ret) begin
                cmp_pat  <= step_pat(mode_q, cmp_pat);
                cmp_addr <= cmp_addr + ADDR_W'(1);
                if (mismatch) begin
                    if (ERR_COUNT == '0) begin
                        FIRST_ERR_ADDR <= cmp_addr;
                        FIRST_ERR_DATA <= MEM_RDATA;
                    end
                    if (ERR_COUNT != {ERR_W{1'b1}}) ERR_COUNT <= ERR_COUNT + ERR_W'(1);
                end
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        mode_q         <= MODE;
                        aborted        <= 1'b0;
                        BUSY           <= 1'b1;
                        PASS           <= 1'b0;
                        ERR_COUNT      <= '0;
                        FIRST_ERR_ADDR <= '0;
                        FIRST_ERR_DATA <= '0;
                        wr_left        <= LENGTH;
                        rd_left        <= LENGTH;
                        issue_addr     <= BASE_ADDR;
                        cmp_addr       <= BASE_ADDR;
                        cmp_pat        <= init_pat(MODE, SEED, BASE_ADDR);
                        if (LENGTH == '0) begin
                            state <= S_FINISH;
                        end else begin
                            state     <= S_WRITE;
                            MEM_WR_N  <= 1'b0;
                            MEM_ADDR  <= BASE_ADDR;
                            MEM_WDATA <= init_pat(MODE, SEED, BASE_ADDR);
                        end
                    end
                end

                S_WRITE: begin
                    if (ABORT) aborted <= 1'b1;
                    if (wr_acc) begin
                        if (wr_left == ADDR_W'(1) || ABORT) begin
                            MEM_WR_N <= 1'b1;
                            state    <= ABORT ? S_DRAIN : S_READ;
                        end else begin
                            wr_left   <= wr_left - ADDR_W'(1);
                            MEM_ADDR  <= MEM_ADDR + ADDR_W'(1);
                            MEM_WDATA <= step_pat(mode_q, MEM_WDATA);
                        end
                    end
                end

                S_READ: begin
                    if (ABORT) aborted <= 1'b1;
                    if (rd_acc) begin
                        rd_left <= rd_left - ADDR_W'(1);
                        if (rd_left == ADDR_W'(1) || ABORT) begin
                            MEM_RD_N <= 1'b1;
                            state    <= S_DRAIN;
                        end else if (pend_next < PEND_MAX) begin
                            MEM_RD_N   <= 1'b0;
                            MEM_ADDR   <= issue_addr;
                            issue_addr <= issue_addr + ADDR_W'(1);
                        end else begin
                            MEM_RD_N <= 1'b1;
                        end
                    end else if (MEM_RD_N) begin
                        if (ABORT) begin
                            state <= S_DRAIN;
                        end else if (pend_next < PEND_MAX) begin
                            MEM_RD_N   <= 1'b0;
                            MEM_ADDR   <= issue_addr;
                            issue_addr <= issue_addr + ADDR_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (pending == 4'd0) state <= S_FINISH;
                end

                S_FINISH: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    PASS  <= (ERR_COUNT == '0) && !aborted;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_pattern_tester.sv
module tb_dram_pattern_tester;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        START, ABORT;
    logic [1:0]  MODE;
    logic [24:0] BASE_ADDR, LENGTH;
    logic [15:0] SEED;
    logic        BUSY, DONE, PASS;
    logic [15:0] ERR_COUNT;
    logic [24:0] FIRST_ERR_ADDR;
    logic [15:0] FIRST_ERR_DATA;
    logic [24:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [1:0]  MEM_BE_N;
    logic        MEM_WR_N, MEM_RD_N;
    logic        MEM_WAITREQUEST = 1'b0;
    logic [15:0] MEM_RDATA = 16'h0;
    logic        MEM_RDVALID = 1'b0;

    dram_pattern_tester dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT),
        .MODE(MODE), .BASE_ADDR(BASE_ADDR), .LENGTH(LENGTH), .SEED(SEED),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_COUNT(ERR_COUNT),
        .FIRST_ERR_ADDR(FIRST_ERR_ADDR), .FIRST_ERR_DATA(FIRST_ERR_DATA),
        .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_BE_N(MEM_BE_N),
        .MEM_WR_N(MEM_WR_N), .MEM_RD_N(MEM_RD_N),
        .MEM_WAITREQUEST(MEM_WAITREQUEST), .MEM_RDATA(MEM_RDATA),
        .MEM_RDVALID(MEM_RDVALID)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct { int due; logic [24:0] addr; } rd_t;
    rd_t         rq[$];
    logic [15:0] mem [logic [24:0]];
    int          cyc = 0;
    int          read_lat = 1;
    logic [24:0] stall_addr = 25'h0;
    int          stall_left = 0;
    logic [15:0] stall_data = 16'h0;
    bit          corrupt_en = 1'b0;
    logic [24:0] corrupt_addr = 25'h0;
    int          wr_low, outstanding, max_out, wfirst, wlast;
    logic [15:0] wlog[$];
    logic [24:0] waddr[$];
    logic [24:0] raddr[$];
    rd_t         r;

    // Runs at negedge: strobes are stable, and WAITREQUEST set here is what
    // the DUT sees at the next posedge, so acceptance is decided here.
    always @(negedge CLK) begin
        cyc++;
        MEM_RDVALID = 1'b0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            MEM_RDVALID = 1'b1;
            if (corrupt_en && r.addr == corrupt_addr) MEM_RDATA = 16'hDEAD;
            else MEM_RDATA = mem.exists(r.addr) ? mem[r.addr] : 16'h0;
            outstanding--;
        end
        MEM_WAITREQUEST = 1'b0;
        if (!MEM_WR_N && MEM_ADDR == stall_addr && stall_left > 0) begin
            MEM_WAITREQUEST = 1'b1;
            stall_left--;
            check_val("stall_hold_wdata", MEM_WDATA, stall_data);
        end
        if (!MEM_WR_N) wr_low++;
        if (!MEM_WR_N && !MEM_WAITREQUEST) begin
            mem[MEM_ADDR] = MEM_WDATA;
            if (wlog.size() == 0) wfirst = cyc;
            wlast = cyc;
            wlog.push_back(MEM_WDATA);
            waddr.push_back(MEM_ADDR);
        end
        if (!MEM_RD_N && !MEM_WAITREQUEST) begin
            rq.push_back('{cyc + read_lat, MEM_ADDR});
            raddr.push_back(MEM_ADDR);
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
        end
    end

    // ---------------- run helper ----------------
    task automatic run_op(input logic [1:0] m, input logic [24:0] b, input logic [24:0] l,
                          input logic [15:0] s, input int lat, input int abort_after,
                          output int waited);
        bit done_seen;
        wlog.delete(); waddr.delete(); raddr.delete();
        wr_low = 0; outstanding = 0; max_out = 0; read_lat = lat;
        MODE = m; BASE_ADDR = b; LENGTH = l; SEED = s;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check_val("busy_after_start", BUSY, 1);
        done_seen = 1'b0;
        waited = 0;
        for (int n = 0; n < 3000; n++) begin
            if (abort_after >= 0 && wlog.size() >= abort_after) ABORT = 1'b1;
            if (DONE) begin
                done_seen = 1'b1;
                waited = n;
                break;
            end
            @(negedge CLK);
        end
        ABORT = 1'b0;
        check_val("done_seen", done_seen, 1);
    endtask

    task automatic done_pulse_ends();
        @(negedge CLK);
        check_val("done_one_cycle", DONE, 0);
        check_val("busy_after_done", BUSY, 0);
    endtask

    int w;
    logic [15:0] exp_d;

    initial begin
        RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
        MODE = 2'd0; BASE_ADDR = '0; LENGTH = '0; SEED = '0;
        repeat (3) @(negedge CLK);
        check_val("rst_wr_n", MEM_WR_N, 1);
        check_val("rst_rd_n", MEM_RD_N, 1);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_pass", PASS, 0);
        check_val("rst_err", ERR_COUNT, 0);
        check_val("rst_addr", MEM_ADDR, 0);
        check_val("rst_wdata", MEM_WDATA, 0);
        check_val("be_n", MEM_BE_N, 0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Affine, no stall: 7,10,...,28 back-to-back
        run_op(2'd1, 25'h0, 25'd8, 16'd7, 1, -1, w);
        check_val("aff_pass", PASS, 1);
        check_val("aff_err", ERR_COUNT, 0);
        check_val("aff_nwr", wlog.size(), 8);
        for (int i = 0; i < 8 && i < wlog.size(); i++) begin
            exp_d = 16'(7 + 3 * i);
            check_val($sformatf("aff_wdata%0d", i), wlog[i], exp_d);
        end
        check_val("aff_wr_low", wr_low, 8);
        check_val("aff_wr_span", wlast - wfirst, 7);
        check_val("aff_nrd", raddr.size(), 8);
        done_pulse_ends();

        // Stall three cycles on word 2
        stall_addr = 25'd2; stall_left = 3; stall_data = 16'd13;
        run_op(2'd1, 25'h0, 25'd8, 16'd7, 1, -1, w);
        check_val("stl_pass", PASS, 1);
        check_val("stl_wr_low", wr_low, 11);
        check_val("stl_wr_span", wlast - wfirst, 10);
        check_val("stl_left", stall_left, 0);
        check_val("stl_wdata7", wlog.size() == 8 ? wlog[7] : 16'hFFFF, 28);
        done_pulse_ends();

        // Corrupted read at address 5
        corrupt_en = 1'b1; corrupt_addr = 25'd5;
        run_op(2'd0, 25'h0, 25'd16, 16'd0, 1, -1, w);
        check_val("cor_err", ERR_COUNT, 1);
        check_val("cor_faddr", FIRST_ERR_ADDR, 5);
        check_val("cor_fdata", FIRST_ERR_DATA, 16'hDEAD);
        check_val("cor_pass", PASS, 0);
        corrupt_en = 1'b0;
        done_pulse_ends();

        // Pipelined reads over the address wrap, latency 6
        run_op(2'd0, 25'h1FF_FFFE, 25'd4, 16'h1234, 6, -1, w);
        check_val("wrp_pass", PASS, 1);
        check_val("wrp_nrd", raddr.size(), 4);
        if (raddr.size() == 4) begin
            check_val("wrp_ra0", raddr[0], 25'h1FF_FFFE);
            check_val("wrp_ra1", raddr[1], 25'h1FF_FFFF);
            check_val("wrp_ra2", raddr[2], 25'h0);
            check_val("wrp_ra3", raddr[3], 25'h1);
        end
        check_val("wrp_max_pend", max_out, 4);
        check_val("wrp_wa2", waddr.size() == 4 ? waddr[2] : 25'h1FF_FFFF, 25'h0);
        done_pulse_ends();

        // Abort during WRITE
        run_op(2'd0, 25'h100, 25'd16, 16'd0, 1, 3, w);
        check_val("abt_pass", PASS, 0);
        check_val("abt_partial", (wlog.size() >= 3 && wlog.size() < 16), 1);
        check_val("abt_no_reads", raddr.size(), 0);
        done_pulse_ends();

        // Empty window
        run_op(2'd0, 25'h0, 25'd0, 16'd0, 1, -1, w);
        check_val("len0_latency", w, 1);
        check_val("len0_pass", PASS, 1);
        check_val("len0_no_wr", wr_low, 0);
        check_val("len0_no_rd", raddr.size(), 0);
        done_pulse_ends();

        // Address complement
        run_op(2'd3, 25'h10, 25'd3, 16'd0, 2, -1, w);
        check_val("cmp_pass", PASS, 1);
        if (wlog.size() == 3) begin
            check_val("cmp_w0", wlog[0], 16'hFFEF);
            check_val("cmp_w1", wlog[1], 16'hFFEE);
            check_val("cmp_w2", wlog[2], 16'hFFED);
        end else check_val("cmp_nwr", wlog.size(), 3);
        done_pulse_ends();

        // Mode 2 without the LFSR build matches increment mode
        run_op(2'd2, 25'h20, 25'd3, 16'd5, 1, -1, w);
        check_val("m2_pass", PASS, 1);
        if (wlog.size() == 3) begin
            check_val("m2_w0", wlog[0], 16'd5);
            check_val("m2_w2", wlog[2], 16'd7);
        end else check_val("m2_nwr", wlog.size(), 3);
        done_pulse_ends();

        // Reset while reads are in flight
        wlog.delete(); raddr.delete(); read_lat = 6; outstanding = 0;
        MODE = 2'd0; BASE_ADDR = 25'h200; LENGTH = 25'd16; SEED = 16'd0;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int n = 0; n < 300 && MEM_RD_N; n++) @(negedge CLK);
        check_val("rst_mid_in_read", MEM_RD_N, 0);
        #2 RESET_N = 1'b0;
        #1;
        check_val("rst_mid_rd_n", MEM_RD_N, 1);
        check_val("rst_mid_wr_n", MEM_WR_N, 1);
        check_val("rst_mid_busy", BUSY, 0);
        repeat (8) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        run_op(2'd1, 25'h40, 25'd5, 16'h100, 1, -1, w);
        check_val("post_rst_pass", PASS, 1);
        check_val("post_rst_err", ERR_COUNT, 0);
        done_pulse_ends();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
